// File: rtl/cmd_scheduler.sv
// cmd_scheduler: arbitrates the host and auto-command requesters onto the
// single CMD controller. It launches each command, waits for completion,
// acknowledges it, and returns the response to the requester that won.
// Ports:
//   clock, reset (async, active high)
//   req0_*/req1_*            valid/ready command requests (0 = host, 1 = auto)
//   done0/done1              one-cycle completion pulses to the requesters
//   resp_out, err_out        captured response / watchdog abort flag
//   busy                     high whenever a command is in flight
//   ctl_idle, new_command, cmd_index, cmd_argument,
//   command_complete, enable_command_complete, enable_response,
//   response, ack_response, ack_command_complete   controller side
// Optional feature macro: CMD_SCHED_WDOG_EN enables a WAIT/ACK watchdog.
module cmd_scheduler #(
    parameter int unsigned WDOG_W      = 16,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [5:0]   req0_index,
    input  logic [31:0]  req0_argument,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [5:0]   req1_index,
    input  logic [31:0]  req1_argument,
    output logic         req1_ready,
    output logic         done0,
    output logic         done1,
    output logic [127:0] resp_out,
    output logic         err_out,
    output logic         busy,
    input  logic         ctl_idle,
    output logic         new_command,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_argument,
    input  logic         command_complete,
    input  logic         enable_command_complete,
    input  logic         enable_response,
    input  logic [127:0] response,
    output logic         ack_response,
    output logic         ack_command_complete
);

    // The watchdog limit must be reachable by a WDOG_W-bit counter.
    if (WDOG_CYCLES < 2 ||
        (WDOG_W < 32 && WDOG_CYCLES > (32'd1 << WDOG_W))) begin : g_bad_cfg
        $error("cmd_scheduler: WDOG_CYCLES does not fit in WDOG_W bits");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_grant_q, last_grant_d;
    logic [5:0]     idx_q, idx_d;
    logic [31:0]    arg_q, arg_d;
    logic [127:0]   resp_q, resp_d;
    logic           pick1;
    logic           cmd_done;

`ifdef CMD_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              wdog_hit;

    assign wdog_hit = (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
    assign err_out  = (state_q == S_DONE) && err_q;
`else
    assign err_out  = 1'b0;
`endif

    // On a tie the requester that did not win last time goes next.
    assign pick1    = req1_valid && !(req0_valid && last_grant_q);
    assign cmd_done = command_complete && enable_command_complete
                      && enable_response;

    assign busy         = (state_q != S_IDLE);
    assign cmd_index    = idx_q;
    assign cmd_argument = arg_q;
    assign resp_out     = resp_q;

    always_comb begin
        state_d              = state_q;
        grant_d              = grant_q;
        last_grant_d         = last_grant_q;
        idx_d                = idx_q;
        arg_d                = arg_q;
        resp_d               = resp_q;
        req0_ready           = 1'b0;
        req1_ready           = 1'b0;
        new_command          = 1'b0;
        ack_response         = 1'b0;
        ack_command_complete = 1'b0;
        done0                = 1'b0;
        done1                = 1'b0;
`ifdef CMD_SCHED_WDOG_EN
        wdog_d               = wdog_q;
        err_d                = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ctl_idle && (req0_valid || req1_valid)) begin
                    req0_ready   = !pick1;
                    req1_ready   = pick1;
                    idx_d        = pick1 ? req1_index : req0_index;
                    arg_d        = pick1 ? req1_argument : req0_argument;
                    grant_d      = pick1;
                    last_grant_d = pick1;
                    state_d      = S_ISSUE;
`ifdef CMD_SCHED_WDOG_EN
                    err_d        = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                new_command = 1'b1;
                state_d     = S_WAIT;
`ifdef CMD_SCHED_WDOG_EN
                wdog_d      = '0;
`endif
            end
            S_WAIT: begin
                if (cmd_done) begin
                    resp_d  = response;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                ack_response         = 1'b1;
                ack_command_complete = 1'b1;
                if (!enable_command_complete) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done0   = !grant_q;
                done1   = grant_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef CMD_SCHED_WDOG_EN
        if (state_q == S_WAIT || state_q == S_ACK) begin
            if (wdog_q != '1) begin
                wdog_d = wdog_q + 1'b1;
            end
            // Timeout overrides any completion seen in the same cycle.
            if (wdog_hit) begin
                state_d              = S_DONE;
                resp_d               = '0;
                err_d                = 1'b1;
                ack_response         = 1'b0;
                ack_command_complete = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            idx_q        <= '0;
            arg_q        <= '0;
            resp_q       <= '0;
`ifdef CMD_SCHED_WDOG_EN
            wdog_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            arg_q        <= arg_d;
            resp_q       <= resp_d;
`ifdef CMD_SCHED_WDOG_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: doc/cmd_scheduler.md
# cmd_scheduler

Arbitrates two command requesters (host register path, auto-command path such as CMD12 from the DAT engine) onto the single CMD controller. The block sequences each command end to end:
- launches it with a one-cycle `new_command` pulse;
- waits for completion;
- acknowledges the response and command-complete flags;
- returns the 128-bit response to the winning requester.

It sits between the register/Wishbone side and the CMD controller, which it drives and observes.

## Interface
- `WDOG_W`, 16, width of watchdog counter.
- `WDOG_CYCLES`, 4096, cycles allowed in WAIT+ACK before abort (only with `CMD_SCHED_WDOG_EN`).
- `clock` in 1, system clock.
- `reset` in 1, asynchronous, active-high reset.
- `req0_valid` in 1, requester 0 (host) has a command; holds until accepted.
- `req0_index` in 6, command index.
- `req0_argument` in 32, command argument.
- `req0_ready` out 1, combinational accept, high for one cycle.
- `req1_valid`, `req1_index`, `req1_argument`, `req1_ready`: same for requester 1 (auto-command).
- `done0` / `done1` out 1, one-cycle completion pulse to requester.
- `resp_out` out 128, captured response; valid while a `doneN` is high and held until the next capture.
- `err_out` out 1, high with `doneN` when the command was aborted by the watchdog.
- `busy` out 1, high in every state except IDLE.
- `ctl_idle` in 1, controller idle indication (`idle_out` of the controller).
- `new_command` out 1, launch pulse to the controller.
- `cmd_index` out 6, registered index.
- `cmd_argument` out 32, registered argument.
- `command_complete` in 1, from controller.
- `enable_command_complete` in 1, from controller.
- `enable_response` in 1, from controller.
- `response` in 128, from controller.
- `ack_response` out 1, read acknowledge to controller.
- `ack_command_complete` out 1, read acknowledge to controller.

## Operation
States: IDLE, ISSUE, WAIT, ACK, DONE. Reset value is IDLE; `last_grant`=1.

All outputs reset to 0: `resp_out`=0, `cmd_index`=0, `cmd_argument`=0.

**IDLE**
- Arbitration runs only when `ctl_idle`=1.
- If exactly one `valid` is high, that requester wins.
- If both are high, round robin: the requester not equal to `last_grant` wins.
- The winner's `reqN_ready`=1 in that cycle.
- On the clock edge: latch index and argument into `cmd_index`/`cmd_argument`, record `grant`, update `last_grant`, go to ISSUE.

**ISSUE**
- `new_command`=1 for exactly this cycle, then go to WAIT.

**WAIT**
- When `command_complete`, `enable_command_complete` and `enable_response` are all 1: `resp_out` <= `response`, go to ACK.

**ACK**
- `ack_response`=1 and `ack_command_complete`=1.
- Stay in ACK while `enable_command_complete`=1.
- When it drops to 0, go to DONE.

**DONE**
- `done[grant]`=1 for one cycle, `err_out`=0, then go to IDLE.

Rules across all states:
- `cmd_index`/`cmd_argument` stay stable from ISSUE until the next acceptance.
- `reqN_ready` is never asserted outside IDLE.
- A request that arrives while busy waits. Requesters must hold `valid` and data until `ready`.

## Timing
- Accept to `new_command`: 1 cycle (edge after `ready`).
- Capture to `ack_*`: `resp_out` updates on the edge leaving WAIT; `ack_*` are high from the next cycle.
- `doneN` follows the edge after `enable_command_complete` falls.
- Minimum turnaround from DONE back to IDLE: 1 cycle, so back-to-back grants are at least 5 cycles apart.
- Reset asserted mid-command:
  - All state and outputs clear immediately.
  - Pending or in-flight commands are dropped; no `doneN` pulse.
  - Requesters re-present after reset.
- Simultaneous `valid` rising on both requesters in the first cycle after reset: req0 wins.
- `ctl_idle`=0 while in IDLE: no grant; `ready` stays 0.

## Configuration
`CMD_SCHED_WDOG_EN` defined:
- A `WDOG_W`-bit counter clears on entry to WAIT and increments each cycle in WAIT or ACK.
- When the counter equals `WDOG_CYCLES-1`: go to DONE with `err_out`=1 and `resp_out`=0, and drop `ack_*`.
- The counter saturates; there is no wrap-around.

`CMD_SCHED_WDOG_EN` undefined:
- No counter; WAIT/ACK wait indefinitely.
- `err_out` is tied to 0.

## Test plan
- Single req0, index 6'd17, arg 32'h0000_0200; controller model completes after 20 cycles with `response`=128'hA5 -> `req0_ready` 1 cycle, `new_command` pulse with `cmd_index`=17, `resp_out`=128'hA5 at `done0`, `err_out`=0.
- Both valid the cycle after reset -> req0 granted first, req1 granted next. Repeat with both valid -> order alternates 0,1,0,1.
- req1 asserted during a req0 command -> `req1_ready` only after `done0`, at least 1 IDLE cycle later; req0 `cmd_argument` stable throughout.
- Controller holds `enable_command_complete`=1 for 5 cycles after the ack -> `ack_*` held 5 cycles, then `done` pulse exactly once.
- `reset` pulsed in WAIT -> all outputs 0 asynchronously, state IDLE, no `done`. With `CMD_SCHED_WDOG_EN` and `WDOG_CYCLES`=16 and no completion -> `done0`+`err_out` at cycle 16 of WAIT, `resp_out`=0.
